// File: rtl/clock_phase_gen.sv
// clock_phase_gen: two-phase, non-overlapping clock-enable generator for the
// latch-based datapath. Produces registered complementary enable pairs
// PHI1/nPHI1 (master rank) and PHI2/nPHI2 (slave rank), with run/halt,
// single-step control and a completed-cycle counter for the debug LEDs.
//
// Ports:
//   clk_i        board oscillator, all state changes on its rising edge
//   rst_i        asynchronous active-high reset
//   run_i        level, free-running when high
//   step_i       debounced button level, rising edge requests one CPU cycle
//   div_i        phase length minus 1, in clk_i cycles
//   phi1_o       master-rank latch enable
//   nphi1_o      complement of phi1_o
//   phi2_o       slave-rank latch enable
//   nphi2_o      complement of phi2_o
//   halted_o     high while the FSM is in HALT
//   cycle_cnt_o  completed CPU cycles, wraps modulo 2^CNT_W
module clock_phase_gen #(
  parameter int unsigned DIV_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             run_i,
  input  logic             step_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             phi1_o,
  output logic             nphi1_o,
  output logic             phi2_o,
  output logic             nphi2_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [2:0] {
    StHalt,
    StP1,
    StG1,
    StP2,
    StG2
  } state_e;

  state_e             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic               step_q;
  logic               step_edge;

  logic phi1_q, nphi1_q, phi2_q, nphi2_q, halted_q;

  assign step_edge = step_i & ~step_q;

  // Next-state logic. The divider is loaded on entry to each phase so a DIV
  // change mid-phase only affects the following phase.
  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    cycle_cnt_d = cycle_cnt_q;

    unique case (state_q)
      StHalt: begin
        // Step edges are only honoured here; elsewhere they are dropped.
        if (run_i || step_edge) begin
          state_d   = StP1;
          div_cnt_d = div_i;
        end
      end
      StP1: begin
        if (div_cnt_q == '0) begin
          state_d = StG1;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      StG1: begin
        state_d   = StP2;
        div_cnt_d = div_i;
      end
      StP2: begin
        if (div_cnt_q == '0) begin
          state_d = StG2;
        end else begin
          div_cnt_d = div_cnt_q - 1'b1;
        end
      end
      StG2: begin
        cycle_cnt_d = cycle_cnt_q + 1'b1;
        // RUN is only consulted at the cycle boundary, so dropping it never
        // truncates a phase.
        if (run_i) begin
          state_d   = StP1;
          div_cnt_d = div_i;
        end else begin
          state_d = StHalt;
        end
      end
      default: begin
        state_d = StHalt;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StHalt;
      div_cnt_q   <= '0;
      cycle_cnt_q <= '0;
      step_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      cycle_cnt_q <= cycle_cnt_d;
      step_q      <= step_i;
    end
  end

  // Outputs are flops decoded from the next state: glitch-free, no input to
  // PHI path, and each complement is its own flop so the pair never skews.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      phi1_q   <= 1'b0;
      nphi1_q  <= 1'b1;
      phi2_q   <= 1'b0;
      nphi2_q  <= 1'b1;
      halted_q <= 1'b1;
    end else begin
      phi1_q   <= (state_d == StP1);
      nphi1_q  <= (state_d != StP1);
      phi2_q   <= (state_d == StP2);
      nphi2_q  <= (state_d != StP2);
      halted_q <= (state_d == StHalt);
    end
  end

  assign phi1_o      = phi1_q;
  assign nphi1_o     = nphi1_q;
  assign phi2_o      = phi2_q;
  assign nphi2_o     = nphi2_q;
  assign halted_o    = halted_q;
  assign cycle_cnt_o = cycle_cnt_q;

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed self-checking bench for clock_phase_gen. A second instance with a
// 4-bit cycle counter shares all inputs and is used for the wrap check.
module tb_clock_phase_gen;

  logic        clk;
  logic        rst;
  logic        run;
  logic        step;
  logic [7:0]  div;

  logic        phi1, nphi1, phi2, nphi2, halted;
  logic [15:0] cnt;
  logic        w_phi1, w_nphi1, w_phi2, w_nphi2, w_halted;
  logic [3:0]  w_cnt;

  int n_cmp;
  int n_err;

  clock_phase_gen #(
    .DIV_W(8),
    .CNT_W(16)
  ) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .run_i      (run),
    .step_i     (step),
    .div_i      (div),
    .phi1_o     (phi1),
    .nphi1_o    (nphi1),
    .phi2_o     (phi2),
    .nphi2_o    (nphi2),
    .halted_o   (halted),
    .cycle_cnt_o(cnt)
  );

  clock_phase_gen #(
    .DIV_W(8),
    .CNT_W(4)
  ) u_dut_w (
    .clk_i      (clk),
    .rst_i      (rst),
    .run_i      (run),
    .step_i     (step),
    .div_i      (div),
    .phi1_o     (w_phi1),
    .nphi1_o    (w_nphi1),
    .phi2_o     (w_phi2),
    .nphi2_o    (w_nphi2),
    .halted_o   (w_halted),
    .cycle_cnt_o(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // {phi1, nphi1, phi2, nphi2, halted}
  function automatic logic [31:0] exp_v(input bit p1, input bit p2, input bit h);
    return {27'd0, p1, ~p1, p2, ~p2, h};
  endfunction

  function automatic logic [31:0] obs_v();
    return {27'd0, phi1, nphi1, phi2, nphi2, halted};
  endfunction

  // Inputs driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    run  = 1'b0;
    step = 1'b0;
    tick();
    rst  = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    run   = 1'b0;
    step  = 1'b0;
    div   = 8'd0;

    // Reset values
    tick();
    check("rst_vec", obs_v(), exp_v(0, 0, 1));
    check("rst_cnt", {16'd0, cnt}, 32'd0);
    rst = 1'b0;

    // Minimum divider: period 4, PHI2 two cycles after PHI1
    div = 8'd0;
    run = 1'b1;
    for (int i = 0; i <= 40; i++) begin
      tick();
      check("min_div_vec", obs_v(), exp_v((i % 4) == 0, (i % 4) == 2, 0));
    end
    check("min_div_cnt", {16'd0, cnt}, 32'd10);

    // Counter wrap on the 4-bit instance
    do_reset();
    div = 8'd0;
    run = 1'b1;
    for (int i = 0; i <= 68; i++) begin
      tick();
      if (i == 60) check("wrap_cnt15", {28'd0, w_cnt}, 32'd15);
      if (i == 64) check("wrap_cnt0", {28'd0, w_cnt}, 32'd0);
    end
    check("wrap_cnt1", {28'd0, w_cnt}, 32'd1);
    check("wrap_wide_cnt", {16'd0, cnt}, 32'd17);

    // Divider sampling: DIV=2, then DIV=5 written mid-P1
    do_reset();
    div = 8'd2;
    run = 1'b1;
    for (int i = 0; i <= 24; i++) begin
      tick();
      check("div_samp_vec", obs_v(),
            exp_v((i <= 2) || (i >= 8 && i <= 10) || (i >= 19),
                  (i >= 4 && i <= 6) || (i >= 12 && i <= 17), 0));
      if (i == 8) div = 8'd5;
    end

    // Single step with a second, ignored pulse during G1
    do_reset();
    div = 8'd1;
    tick();
    check("step_idle_vec", obs_v(), exp_v(0, 0, 1));
    step = 1'b1;
    for (int i = 0; i <= 10; i++) begin
      tick();
      check("step_vec", obs_v(), exp_v(i <= 1, i == 3 || i == 4, i >= 6));
      if (i == 5) check("step_cnt0", {16'd0, cnt}, 32'd0);
      if (i == 6) check("step_cnt1", {16'd0, cnt}, 32'd1);
      if (i == 0) step = 1'b0;
      if (i == 2) step = 1'b1;
      if (i == 3) step = 1'b0;
    end
    check("step_cnt_end", {16'd0, cnt}, 32'd1);

    // Stop mid-cycle: RUN drops 2 cycles into P1
    do_reset();
    div = 8'd4;
    run = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      check("stop_vec", obs_v(), exp_v(i <= 4, i >= 6 && i <= 10, i >= 12));
      if (i == 11) check("stop_cnt0", {16'd0, cnt}, 32'd0);
      if (i == 1) run = 1'b0;
    end
    check("stop_cnt1", {16'd0, cnt}, 32'd1);

    // Asynchronous reset in the middle of P2
    do_reset();
    div = 8'd3;
    run = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      tick();
      check("rst_mid_vec", obs_v(),
            exp_v((i <= 3) || (i >= 10 && i <= 13),
                  (i >= 5 && i <= 8) || (i >= 15), 0));
      if (i == 15) check("rst_mid_cnt1", {16'd0, cnt}, 32'd1);
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_vec", obs_v(), exp_v(0, 0, 1));
    check("rst_async_cnt", {16'd0, cnt}, 32'd0);
    tick();
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
